// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared constants, note table and FSM state type for the beeper tone stage
//
// Purpose: note frequency table (C4..D6), key count, FSM state encoding and the
//          half-period helper used to build the per-note reload table.
// Ports:   none (package)

package beep_pkg;

   localparam int NUM_KEYS = 16;
   localparam int IDX_W    = 4;

   // Note frequencies in Hz, index 0 = C4 ... index 15 = D6.
   localparam int NOTE_HZ [NUM_KEYS] = '{
      262, 294, 330, 349, 392, 440, 494, 523,
      587, 659, 698, 784, 880, 988, 1047, 1175
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      TAIL = 2'd2
   } state_t;

   // Cycles per half period of note idx; only ever called with constant
   // arguments so it folds to a constant table.
   function automatic int half_period(input int idx, input int clk_hz);
      return clk_hz / (2 * NOTE_HZ[idx]);
   endfunction

endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - lowest-set-bit priority encoder for the pressed-key vector
//
// Purpose: reports whether any key is pressed and the index of the lowest one.
// Ports:
//   keys   in   NUM_KEYS  pressed-key vector, 1 = pressed
//   valid  out  1         at least one key pressed
//   idx    out  IDX_W     index of the lowest set bit (0 when none)

module key_prio_enc
   import beep_pkg::*;
(
   input  logic [NUM_KEYS-1:0] keys,
   output logic                valid,
   output logic [IDX_W-1:0]    idx
);

   // Scan from the top down so the lowest set bit is the last assignment.
   always_comb begin
      valid = |keys;
      idx   = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (keys[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/beep_tone_gen.sv
// rtl/beep_tone_gen.sv - square-wave tone generator driven by the keypad key vector
//
// Purpose: plays the pitch of the lowest pressed key, switches pitch only at a
//          period boundary, and holds a release tail that always ends after a
//          complete high phase.
// Ports:
//   clk       in   1         system clock
//   rst_n     in   1         synchronous reset, active-high
//   key_out   in   NUM_KEYS  pressed-key vector, 1 = pressed, debounced
//   beeper    out  1         square wave to the piezo
//   note_idx  out  IDX_W     index of the note currently sounding
//   active    out  1         high while playing or in the release tail

module beep_tone_gen
   import beep_pkg::*;
#(
   parameter int CLK_HZ  = 12_000_000,
   parameter int TAIL_MS = 20,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_out,
   output logic                beeper,
   output logic [IDX_W-1:0]    note_idx,
   output logic                active
);

   localparam longint TAIL_CYC    = (longint'(TAIL_MS) * longint'(CLK_HZ)) / 1000;
   localparam longint TAIL_LOAD_L = (TAIL_CYC > 0) ? (TAIL_CYC - 1) : 0;
   // The tail counter grows beyond CNT_W only when the tail length needs it.
   localparam int     TAIL_W      = (TAIL_LOAD_L >= (longint'(1) << CNT_W))
                                    ? $clog2(TAIL_LOAD_L + 1) : CNT_W;
   localparam logic [TAIL_W-1:0] TAIL_LOAD = TAIL_W'(TAIL_LOAD_L);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   half_cnt;
   logic [TAIL_W-1:0]  tail_cnt;
   logic               pend_vld;
   logic [IDX_W-1:0]   pend_idx;

   logic               key_vld;
   logic [IDX_W-1:0]   key_idx;

   logic               toggle;
   logic               tail_done;
   logic               stop_now;
   logic               rise_apply;
   logic [IDX_W-1:0]   note_eff;

   // Per-note reload values (half period minus one), constant after elaboration.
   logic [CNT_W-1:0]   half_m1 [NUM_KEYS];

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_half
      assign half_m1[g] = CNT_W'(half_period(g, CLK_HZ) - 1);
   end

   key_prio_enc u_enc (
      .keys  (key_out),
      .valid (key_vld),
      .idx   (key_idx)
   );

   assign toggle     = (half_cnt == '0);
   assign tail_done  = (state == TAIL) && !key_vld && (tail_cnt == '0);
   // Leave the tail only on a low level or at the high->low toggle.
   assign stop_now   = tail_done && (!beeper || toggle);
   // A pending note is only adopted at a low->high toggle.
   assign rise_apply = toggle && !beeper && pend_vld;
   assign note_eff   = rise_apply ? pend_idx : note_idx;

   // State register
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (key_vld) state_nxt = PLAY;
         end
         PLAY: begin
            if (!key_vld) state_nxt = TAIL;
         end
         TAIL: begin
            if (key_vld) begin
               state_nxt = PLAY;
            end else if (stop_now) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      active = (state != IDLE);
   end

   // Tone datapath: half-period counter, level, sounding note and pending note.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         beeper   <= 1'b0;
         note_idx <= '0;
         half_cnt <= '0;
         pend_vld <= 1'b0;
         pend_idx <= '0;
      end else if (state == IDLE) begin
         pend_vld <= 1'b0;
         if (key_vld) begin
            beeper   <= 1'b1;
            note_idx <= key_idx;
            half_cnt <= half_m1[key_idx];
         end else begin
            beeper   <= 1'b0;
         end
      end else if (stop_now) begin
         beeper   <= 1'b0;
         half_cnt <= '0;
         pend_vld <= 1'b0;
      end else begin
         if (toggle) begin
            beeper   <= ~beeper;
            note_idx <= note_eff;
            half_cnt <= half_m1[note_eff];
         end else begin
            half_cnt <= half_cnt - CNT_W'(1);
         end
         // Compare against the note sounding after this edge so that a key
         // matching a just-adopted note does not stay pending.
         if (key_vld) begin
            pend_vld <= (key_idx != note_eff);
            pend_idx <= key_idx;
         end else begin
            pend_vld <= 1'b0;
         end
      end
   end

   // Release tail counter: loaded on key-up, saturates at zero.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         tail_cnt <= '0;
      end else if (state == PLAY && !key_vld) begin
         tail_cnt <= TAIL_LOAD;
      end else if (state == TAIL) begin
         if (tail_cnt != '0) begin
            tail_cnt <= tail_cnt - TAIL_W'(1);
         end
      end else begin
         tail_cnt <= '0;
      end
   end

endmodule
